// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI message sequencer driving register writes and auto-increment reads
module spi_reg_ctrl #(
   parameter int NUM_REGS = 16,
   parameter int AUTO_INC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sel_active,
   input  logic       msg_start,
   input  logic       msg_end,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic [6:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr_en,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [7:0] err_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CMD      = 3'd1;
   localparam logic [2:0] S_WRITE    = 3'd2;
   localparam logic [2:0] S_RD_ISSUE = 3'd3;
   localparam logic [2:0] S_RD_WAIT  = 3'd4;
   localparam logic [2:0] S_READ     = 3'd5;
   localparam logic [2:0] S_DROP     = 3'd6;

   localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
   localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);

   logic [2:0] state;
   logic       wr_pend;
   logic       abort;
   logic [6:0] next_addr;
   logic       addr_illegal;

   // Message teardown: SSEL rising edge or SSEL already released
   assign abort        = msg_end | ~sel_active;
   assign addr_illegal = ({1'b0, rx_byte[6:0]} >= NUM_REGS_W);
   assign next_addr    = (AUTO_INC != 0) ? ((reg_addr == LAST_ADDR) ? 7'd0 : reg_addr + 7'd1)
                                         : reg_addr;
   assign busy         = (state != S_IDLE);

   // Strobes are gated by abort so no register access happens in a tear-down cycle
   assign reg_wr_en = wr_pend & ~abort;
   assign reg_rd_en = (state == S_RD_ISSUE) & ~abort;

   // Sequencer state, address pointer, tx byte staging and error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wr_pend   <= 1'b0;
         tx_byte   <= 8'h00;
         tx_load   <= 1'b0;
         reg_addr  <= 7'd0;
         reg_wdata <= 8'h00;
         err_count <= 8'h00;
      end else begin
         tx_load <= 1'b0;
         wr_pend <= 1'b0;
         if (state == S_IDLE) begin
            if (msg_start) state <= S_CMD;
         end else if (abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_CMD: begin
                  if (rx_valid) begin
                     if (addr_illegal) begin
                        state   <= S_DROP;
                        tx_byte <= 8'hFF;
                        tx_load <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                     end else begin
                        reg_addr <= rx_byte[6:0];
                        state    <= rx_byte[7] ? S_RD_ISSUE : S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  if (wr_pend) reg_addr <= next_addr;
                  if (rx_valid) begin
                     wr_pend   <= 1'b1;
                     reg_wdata <= rx_byte;
                     tx_byte   <= rx_byte;
                     tx_load   <= 1'b1;
                  end
               end
               S_RD_ISSUE: state <= S_RD_WAIT;
               S_RD_WAIT: begin
                  tx_byte  <= reg_rdata;
                  tx_load  <= 1'b1;
                  reg_addr <= next_addr;
                  state    <= S_READ;
               end
               S_READ: begin
                  if (rx_valid) state <= S_RD_ISSUE;
               end
               S_DROP: state <= S_DROP;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
